// File: rtl/sumador_serie.sv
// -----------------------------------------------------------------------------
// sumador_serie
//   Multi-cycle serial adder/subtractor. A single STEP-bit adder slice and a
//   registered carry are reused over C = WIDTH/STEP clock cycles to add or
//   subtract two WIDTH-bit operands. Operands and results move over
//   valid/ready handshakes.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand bundle valid
//   in_ready   out  operands can be accepted (state IDLE)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in (add only)
//   sub        in   0: a + b + cin, 1: a - b
//   out_valid  out  result valid (state DONE)
//   out_ready  in   consumer takes the result
//   sum        out  WIDTH-bit result, modulo 2^WIDTH
//   cout       out  carry out of MSB (for subtraction, 1 = no borrow)
//   ovf        out  two's-complement overflow
//   busy       out  high while the slice is iterating (state RUN)
// -----------------------------------------------------------------------------
module sumador_serie #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam bit BAD_PARAMS = (WIDTH < 2) || (STEP < 1) ||
                              ((STEP >= 1) && ((WIDTH % STEP) != 0));
  localparam int C  = (STEP >= 1) ? (WIDTH / STEP) : 1;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  generate
    if (BAD_PARAMS) begin : g_bad_params
      $error("sumador_serie: WIDTH must be >= 2 and STEP must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic [STEP:0]    w_slice;
  logic [WIDTH-1:0] w_res_next;
  logic             w_c_into_msb;
  logic             w_last;

  // One STEP-bit slice of the adder; bit STEP is the carry out of the chunk.
  assign w_slice = {1'b0, r_a[STEP-1:0]} + {1'b0, r_b[STEP-1:0]} +
                   {{STEP{1'b0}}, r_carry};

  // Partial sum enters at the top; everything moves down by one chunk.
  assign w_res_next = WIDTH'({w_slice[STEP-1:0], r_res} >> STEP);

  // Carry into the top bit of the slice, recovered from the sum bit of that
  // position. Only meaningful on the last chunk, where that bit is the MSB.
  assign w_c_into_msb = r_a[STEP-1] ^ r_b[STEP-1] ^ w_slice[STEP-1];

  assign w_last = (r_cnt == CW'(C - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1, so the +1 rides in on the carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> STEP;
          r_b     <= r_b >> STEP;
          r_res   <= w_res_next;
          r_carry <= w_slice[STEP];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum       <= w_res_next;
            r_cout      <= w_slice[STEP];
            r_ovf       <= w_c_into_msb ^ w_slice[STEP];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_sumador_serie.sv
// -----------------------------------------------------------------------------
// tb_sumador_serie
//   Bench for sumador_serie. Two instances share clock and reset: index 0 is
//   WIDTH 8 / STEP 1 (8-cycle latency), index 1 is WIDTH 8 / STEP 4
//   (2-cycle latency). Expected results come from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_sumador_serie;

  logic       clk;
  logic       rst;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] a         [2];
  logic [7:0] b         [2];
  logic       cin       [2];
  logic       sub       [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] sum       [2];
  logic       cout      [2];
  logic       ovf       [2];
  logic       busy      [2];

  int checks   = 0;
  int failures = 0;

  int lat_exp [2];

  sumador_serie #(.WIDTH(8), .STEP(1)) dut_s1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]), .busy(busy[0])
  );

  sumador_serie #(.WIDTH(8), .STEP(4)) dut_s4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Arithmetic meaning of the operation, independent of how it is computed.
  function automatic void ref_model(input logic [7:0] x, input logic [7:0] y,
                                    input logic ci, input logic sb,
                                    output logic [7:0] s, output logic co,
                                    output logic ov);
    int ux, uy, sx, sy, ures, sres;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      ures = ux - uy;
      sres = sx - sy;
      co   = (ux >= uy);
    end else begin
      ures = ux + uy + int'(ci);
      sres = sx + sy + int'(ci);
      co   = (ures > 255);
    end
    s  = ures[7:0];
    ov = (sres > 127) || (sres < -128);
  endfunction

  // Issue one operation and wait (bounded) for out_valid. lat is the number
  // of clock edges after the accept edge; -1 if the result never appeared.
  task automatic do_op(input int d, input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input logic sb,
                       output logic rdy, output int lat,
                       output logic [7:0] s, output logic co, output logic ov);
    @(negedge clk);
    rdy         = in_ready[d];
    a[d]        = x;
    b[d]        = y;
    cin[d]      = ci;
    sub[d]      = sb;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    // Scramble operands: only the accept edge may sample them.
    a[d]        = 8'($urandom);
    b[d]        = 8'($urandom);
    cin[d]      = 1'($urandom);
    sub[d]      = 1'($urandom);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid[d]) begin
        lat = n;
        break;
      end
    end
    s  = sum[d];
    co = cout[d];
    ov = ovf[d];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = 1'($urandom);
        out_ready[d] = 1'($urandom);
        a[d]         = 8'($urandom);
        b[d]         = 8'($urandom);
        cin[d]       = 1'($urandom);
        sub[d]       = 1'($urandom);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      checks += 6;
      if (in_ready[d] !== 1'b1)  begin failures++; $display("FAIL reset_in_ready d=%0d got=%b exp=1", d, in_ready[d]); end
      if (out_valid[d] !== 1'b0) begin failures++; $display("FAIL reset_out_valid d=%0d got=%b exp=0", d, out_valid[d]); end
      if (busy[d] !== 1'b0)      begin failures++; $display("FAIL reset_busy d=%0d got=%b exp=0", d, busy[d]); end
      if (sum[d] !== 8'h00)      begin failures++; $display("FAIL reset_sum d=%0d got=%h exp=00", d, sum[d]); end
      if (cout[d] !== 1'b0)      begin failures++; $display("FAIL reset_cout d=%0d got=%b exp=0", d, cout[d]); end
      if (ovf[d] !== 1'b0)       begin failures++; $display("FAIL reset_ovf d=%0d got=%b exp=0", d, ovf[d]); end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    rst = 1'b0;
    $display("reset: checked both instances after 3 reset cycles");
  endtask

  task automatic test_add_latency();
    logic rdy, co, ov;
    int lat;
    logic [7:0] s;
    do_op(0, 8'd200, 8'd100, 1'b1, 1'b0, rdy, lat, s, co, ov);
    checks += 5;
    if (rdy !== 1'b1)  begin failures++; $display("FAIL add_ready got=%b exp=1", rdy); end
    if (lat != 8)      begin failures++; $display("FAIL add_latency got=%0d exp=8", lat); end
    if (s !== 8'd45)   begin failures++; $display("FAIL add_sum got=%0d exp=45", s); end
    if (co !== 1'b1)   begin failures++; $display("FAIL add_cout got=%b exp=1", co); end
    if (ov !== 1'b0)   begin failures++; $display("FAIL add_ovf got=%b exp=0", ov); end
    $display("add: 200+100+1 -> sum=%0d cout=%b ovf=%b lat=%0d", s, co, ov, lat);
  endtask

  task automatic test_overflow();
    logic rdy, co, ov;
    int lat;
    logic [7:0] s;
    do_op(0, 8'd127, 8'd1, 1'b0, 1'b0, rdy, lat, s, co, ov);
    checks += 3;
    if (s !== 8'h80) begin failures++; $display("FAIL ovf_add_sum got=%h exp=80", s); end
    if (co !== 1'b0) begin failures++; $display("FAIL ovf_add_cout got=%b exp=0", co); end
    if (ov !== 1'b1) begin failures++; $display("FAIL ovf_add_ovf got=%b exp=1", ov); end
    $display("ovf: 127+1 -> sum=%h cout=%b ovf=%b", s, co, ov);
    do_op(0, 8'd5, 8'd7, 1'b1, 1'b1, rdy, lat, s, co, ov);
    checks += 3;
    if (s !== 8'hFE) begin failures++; $display("FAIL sub_neg_sum got=%h exp=fe", s); end
    if (co !== 1'b0) begin failures++; $display("FAIL sub_neg_cout got=%b exp=0", co); end
    if (ov !== 1'b0) begin failures++; $display("FAIL sub_neg_ovf got=%b exp=0", ov); end
    $display("sub: 5-7 -> sum=%h cout=%b ovf=%b", s, co, ov);
  endtask

  task automatic test_step4();
    logic rdy, co, ov;
    int lat;
    logic [7:0] s;
    do_op(1, 8'h80, 8'h01, 1'b0, 1'b1, rdy, lat, s, co, ov);
    checks += 4;
    if (lat != 2)    begin failures++; $display("FAIL step4_latency got=%0d exp=2", lat); end
    if (s !== 8'h7F) begin failures++; $display("FAIL step4_sum got=%h exp=7f", s); end
    if (co !== 1'b1) begin failures++; $display("FAIL step4_cout got=%b exp=1", co); end
    if (ov !== 1'b1) begin failures++; $display("FAIL step4_ovf got=%b exp=1", ov); end
    $display("step4: 0x80-0x01 -> sum=%h cout=%b ovf=%b lat=%0d", s, co, ov, lat);
  endtask

  // Random back-to-back traffic: each op is issued the cycle in_ready returns.
  task automatic test_back_to_back();
    logic rdy, co, ov, eco, eov, ci, sb;
    int lat;
    logic [7:0] s, es, x, y;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 25; k++) begin
        x  = 8'($urandom);
        y  = 8'($urandom);
        ci = 1'($urandom);
        sb = 1'($urandom);
        ref_model(x, y, ci, sb, es, eco, eov);
        do_op(d, x, y, ci, sb, rdy, lat, s, co, ov);
        checks += 5;
        if (rdy !== 1'b1)     begin failures++; $display("FAIL b2b_ready d=%0d got=%b exp=1", d, rdy); end
        if (lat != lat_exp[d]) begin failures++; $display("FAIL b2b_latency d=%0d got=%0d exp=%0d", d, lat, lat_exp[d]); end
        if (s !== es)         begin failures++; $display("FAIL b2b_sum d=%0d a=%h b=%h cin=%b sub=%b got=%h exp=%h", d, x, y, ci, sb, s, es); end
        if (co !== eco)       begin failures++; $display("FAIL b2b_cout d=%0d a=%h b=%h cin=%b sub=%b got=%b exp=%b", d, x, y, ci, sb, co, eco); end
        if (ov !== eov)       begin failures++; $display("FAIL b2b_ovf d=%0d a=%h b=%h cin=%b sub=%b got=%b exp=%b", d, x, y, ci, sb, ov, eov); end
        $display("op d=%0d a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d", d, x, y, ci, sb, s, co, ov, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic rdy, co, ov, eco, eov;
    int lat;
    logic [7:0] s, es, x, y;
    out_ready[0] = 1'b0;
    x = 8'($urandom);
    y = 8'($urandom);
    ref_model(x, y, 1'b0, 1'b0, es, eco, eov);
    do_op(0, x, y, 1'b0, 1'b0, rdy, lat, s, co, ov);
    checks += 1;
    if (s !== es) begin failures++; $display("FAIL bp_first_sum got=%h exp=%h", s, es); end
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = ~in_valid[0];
      a[0]        = 8'($urandom);
      b[0]        = 8'($urandom);
      @(negedge clk);
      checks += 5;
      if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", c, out_valid[0]); end
      if (in_ready[0] !== 1'b0)  begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready[0]); end
      if (sum[0] !== es)         begin failures++; $display("FAIL bp_sum cyc=%0d got=%h exp=%h", c, sum[0], es); end
      if (cout[0] !== eco)       begin failures++; $display("FAIL bp_cout cyc=%0d got=%b exp=%b", c, cout[0], eco); end
      if (ovf[0] !== eov)        begin failures++; $display("FAIL bp_ovf cyc=%0d got=%b exp=%b", c, ovf[0], eov); end
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    checks += 3;
    if (in_ready[0] !== 1'b1)  begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready[0]); end
    if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid[0]); end
    if (sum[0] !== es)         begin failures++; $display("FAIL bp_release_sum_hold got=%h exp=%h", sum[0], es); end
    x = 8'($urandom);
    y = 8'($urandom);
    ref_model(x, y, 1'b1, 1'b1, es, eco, eov);
    do_op(0, x, y, 1'b1, 1'b1, rdy, lat, s, co, ov);
    checks += 3;
    if (s !== es)   begin failures++; $display("FAIL bp_next_sum got=%h exp=%h", s, es); end
    if (co !== eco) begin failures++; $display("FAIL bp_next_cout got=%b exp=%b", co, eco); end
    if (ov !== eov) begin failures++; $display("FAIL bp_next_ovf got=%b exp=%b", ov, eov); end
    $display("backpressure: held 5 cycles, next op a=%h b=%h sub -> sum=%h", x, y, s);
  endtask

  task automatic test_reset_mid_run();
    logic rdy, co, ov;
    int lat;
    logic [7:0] s;
    // Leave a non-zero result behind so the reset clearing it is visible.
    do_op(0, 8'd10, 8'd20, 1'b0, 1'b0, rdy, lat, s, co, ov);
    checks += 1;
    if (s !== 8'd30) begin failures++; $display("FAIL mid_pre_sum got=%0d exp=30", s); end
    @(negedge clk);
    a[0] = 8'hF0; b[0] = 8'h33; cin[0] = 1'b1; sub[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks += 1;
    if (busy[0] !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy[0]); end
    rst = 1'b1;
    #1;
    checks += 5;
    if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid[0]); end
    if (sum[0] !== 8'h00)      begin failures++; $display("FAIL mid_sum got=%h exp=00", sum[0]); end
    if (busy[0] !== 1'b0)      begin failures++; $display("FAIL mid_busy_clr got=%b exp=0", busy[0]); end
    if (in_ready[0] !== 1'b1)  begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready[0]); end
    if (cout[0] !== 1'b0)      begin failures++; $display("FAIL mid_cout got=%b exp=0", cout[0]); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    do_op(0, 8'd1, 8'd2, 1'b0, 1'b0, rdy, lat, s, co, ov);
    checks += 3;
    if (lat != 8)     begin failures++; $display("FAIL mid_after_latency got=%0d exp=8", lat); end
    if (s !== 8'd3)   begin failures++; $display("FAIL mid_after_sum got=%0d exp=3", s); end
    if (co !== 1'b0)  begin failures++; $display("FAIL mid_after_cout got=%b exp=0", co); end
    $display("reset mid-run: recovered, 1+2 -> sum=%0d lat=%0d", s, lat);
  endtask

  initial begin
    lat_exp[0] = 8;
    lat_exp[1] = 2;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      a[d]         = '0;
      b[d]         = '0;
      cin[d]       = 1'b0;
      sub[d]       = 1'b0;
    end
    rst = 1'b1;
    test_reset();
    test_add_latency();
    test_overflow();
    test_step4();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
